// File: rtl/usi_spi_master_drv.sv
// usi_spi_master_drv: mode-0 SPI master byte engine (MSB first, 8-bit frames).
// Bytes enter over a valid/ready handshake. Received bytes leave as a one-cycle
// rx_valid strobe. The SCK half period is cfg_half_div+1 cpu_clk cycles.
module usi_spi_master_drv #(
  parameter int DIV_W = 8
) (
  input  logic             cpu_clk,
  input  logic             pad_cpu_rst_b,
  input  logic [DIV_W-1:0] cfg_half_div,
  input  logic             cfg_nss_hold,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             busy,
  output logic             spi_nss,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
  logic [DIV_W-1:0] half_r, half_s;
  logic             hold_r, hold_s;
  logic             gap_ph_r, gap_ph_s;
  logic [2:0]       bit_cnt_r, bit_cnt_s;
  logic [7:0]       tx_sh_r, tx_sh_s;
  logic [7:0]       rx_sh_r, rx_sh_s;
  logic [7:0]       rx_data_r, rx_data_s;
  logic             nss_r, nss_s;
  logic             sck_r, sck_s;
  logic             mosi_r, mosi_s;
  logic             rx_valid_r, rx_valid_s;

  logic             half_done_s;
  logic             end_of_byte_s;
  logic             accept_s;

  // The current phase has lasted its full T cycles.
  assign half_done_s   = (div_cnt_r == half_r);
  // This is the last cycle of the final LOW phase of a byte.
  assign end_of_byte_s = (state_r == ST_LOW) && half_done_s && (bit_cnt_r == 3'd0);
  // In hold mode the next byte can be taken in the end-of-byte cycle, so nss stays low.
  assign tx_ready      = (state_r == ST_IDLE) || (end_of_byte_s && hold_r);
  assign accept_s      = tx_valid && tx_ready;
  assign busy          = (state_r != ST_IDLE);

  assign spi_nss  = nss_r;
  assign spi_sck  = sck_r;
  assign spi_mosi = mosi_r;
  assign rx_valid = rx_valid_r;
  assign rx_data  = rx_data_r;

  // Compute the next state, phase timing, shift registers and pin values.
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = half_done_s ? {DIV_W{1'b0}} : (div_cnt_r + DIV_W'(1));
    half_s     = half_r;
    hold_s     = hold_r;
    gap_ph_s   = gap_ph_r;
    bit_cnt_s  = bit_cnt_r;
    tx_sh_s    = tx_sh_r;
    rx_sh_s    = rx_sh_r;
    rx_data_s  = rx_data_r;
    nss_s      = nss_r;
    sck_s      = sck_r;
    mosi_s     = mosi_r;
    rx_valid_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        div_cnt_s = {DIV_W{1'b0}};
        gap_ph_s  = 1'b0;
        nss_s     = 1'b1;
        sck_s     = 1'b0;
        mosi_s    = 1'b0;
        if (accept_s) begin
          half_s    = cfg_half_div;
          hold_s    = cfg_nss_hold;
          tx_sh_s   = tx_data;
          bit_cnt_s = 3'd7;
          nss_s     = 1'b0;
          mosi_s    = tx_data[7];
          state_s   = ST_SETUP;
        end else begin
          state_s   = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (half_done_s) begin
          sck_s   = 1'b1;
          state_s = ST_HIGH;
        end else begin
          state_s = ST_SETUP;
        end
      end

      ST_HIGH: begin
        // Sample miso just before the falling edge; present the next bit on that same edge.
        if (half_done_s) begin
          rx_sh_s = {rx_sh_r[6:0], spi_miso};
          sck_s   = 1'b0;
          state_s = ST_LOW;
          if (bit_cnt_r != 3'd0) begin
            tx_sh_s = {tx_sh_r[6:0], 1'b0};
            mosi_s  = tx_sh_r[6];
          end else begin
            tx_sh_s = tx_sh_r;
          end
        end else begin
          state_s = ST_HIGH;
        end
      end

      ST_LOW: begin
        if (half_done_s) begin
          if (bit_cnt_r != 3'd0) begin
            bit_cnt_s = bit_cnt_r - 3'd1;
            sck_s     = 1'b1;
            state_s   = ST_HIGH;
          end else begin
            rx_data_s  = rx_sh_r;
            rx_valid_s = 1'b1;
            if (accept_s) begin
              half_s    = cfg_half_div;
              hold_s    = cfg_nss_hold;
              tx_sh_s   = tx_data;
              bit_cnt_s = 3'd7;
              mosi_s    = tx_data[7];
              state_s   = ST_SETUP;
            end else begin
              nss_s     = 1'b1;
              mosi_s    = 1'b0;
              gap_ph_s  = 1'b0;
              state_s   = ST_GAP;
            end
          end
        end else begin
          state_s = ST_LOW;
        end
      end

      ST_GAP: begin
        // The gap lasts two half periods: one pass of the divider per phase bit.
        if (half_done_s) begin
          if (gap_ph_r) begin
            state_s = ST_IDLE;
          end else begin
            gap_ph_s = 1'b1;
            state_s  = ST_GAP;
          end
        end else begin
          state_s = ST_GAP;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        div_cnt_s = {DIV_W{1'b0}};
        nss_s     = 1'b1;
        sck_s     = 1'b0;
        mosi_s    = 1'b0;
      end
    endcase
  end

  // Register all engine state and the registered outputs.
  always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_r    <= ST_IDLE;
      div_cnt_r  <= {DIV_W{1'b0}};
      half_r     <= {DIV_W{1'b0}};
      hold_r     <= 1'b0;
      gap_ph_r   <= 1'b0;
      bit_cnt_r  <= 3'd0;
      tx_sh_r    <= 8'h00;
      rx_sh_r    <= 8'h00;
      rx_data_r  <= 8'h00;
      nss_r      <= 1'b1;
      sck_r      <= 1'b0;
      mosi_r     <= 1'b0;
      rx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      half_r     <= half_s;
      hold_r     <= hold_s;
      gap_ph_r   <= gap_ph_s;
      bit_cnt_r  <= bit_cnt_s;
      tx_sh_r    <= tx_sh_s;
      rx_sh_r    <= rx_sh_s;
      rx_data_r  <= rx_data_s;
      nss_r      <= nss_s;
      sck_r      <= sck_s;
      mosi_r     <= mosi_s;
      rx_valid_r <= rx_valid_s;
    end
  end

endmodule
